sad_accumulator: RTL and testbench

// Streaming sum-of-absolute-differences engine for the SAD datapath.

---
 rtl/sad_accumulator_if.sv | 30 +++
 rtl/sad_accumulator.sv | 109 ++++++++++
 tb/tb_sad_accumulator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_accumulator_if.sv
// sad_accumulator_if
// Groups the pixel-pair input stream and the SAD result stream of the
// sum-of-absolute-differences engine.
//   in_valid / in_ready  : pixel pair handshake (producer -> engine)
//   pix_a / pix_b        : current-block and reference-block pixels, unsigned
//   sad_valid / sad_ready: result handshake (engine -> consumer)
//   sad                  : sum of |pix_a - pix_b| over one block
// Modports: master = producer/consumer side, slave = engine side.
interface sad_accumulator_if #(
    parameter int PIX_W = 8,
    parameter int SUM_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] pix_a;
    logic [PIX_W-1:0] pix_b;
    logic             sad_valid;
    logic             sad_ready;
    logic [SUM_W-1:0] sad;

    modport master (
        output in_valid, pix_a, pix_b, sad_ready,
        input  in_ready, sad_valid, sad
    );

    modport slave (
        input  in_valid, pix_a, pix_b, sad_ready,
        output in_ready, sad_valid, sad
    );
endinterface

// File: rtl/sad_accumulator.sv
// sad_accumulator
// Streaming sum-of-absolute-differences engine. Each accepted pixel pair has
// |a-b| registered in stage 1, then added into the accumulator in stage 2.
// After BLOCK_N accepted pairs the engine stops accepting for one DRAIN cycle
// (last difference lands in acc), then holds the block result until the
// consumer takes it.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   clear  : synchronous abort of the current block (pending result dropped)
//   bus    : sad_accumulator_if.slave - input pair stream and result stream
module sad_accumulator #(
    parameter int PIX_W   = 8,
    parameter int BLOCK_N = 16,
    parameter int SUM_W   = PIX_W + $clog2(BLOCK_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    sad_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(BLOCK_N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_N - 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [SUM_W-1:0]   acc;
    logic [PIX_W-1:0]   absd;
    logic               s1_valid;
    logic               sad_valid_r;

    logic               in_ready_c;
    logic               accept;
    logic signed [PIX_W:0] diff;
    logic [PIX_W-1:0]   absd_next;

    always_comb begin
        // Zero-extended operands make the 9-bit signed difference span
        // -(2^PIX_W-1)..(2^PIX_W-1), so its magnitude always fits PIX_W bits.
        diff       = $signed({1'b0, bus.pix_a}) - $signed({1'b0, bus.pix_b});
        absd_next  = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
        in_ready_c = rst_n & (state == ACCUM) & ~clear;
        accept     = bus.in_valid & in_ready_c;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sad_valid = sad_valid_r;
    assign bus.sad       = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            count       <= '0;
            acc         <= '0;
            absd        <= '0;
            s1_valid    <= 1'b0;
            sad_valid_r <= 1'b0;
        end else if (clear) begin
            state       <= ACCUM;
            count       <= '0;
            acc         <= '0;
            s1_valid    <= 1'b0;
            sad_valid_r <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                absd <= absd_next;
            end
            if (s1_valid) begin
                acc <= acc + SUM_W'(absd);
            end

            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        if (count == LAST) begin
                            count <= '0;
                            state <= DRAIN;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The final difference is added to acc on this edge, so
                    // the result is complete when sad_valid rises.
                    state       <= HOLD;
                    sad_valid_r <= 1'b1;
                end
                HOLD: begin
                    if (bus.sad_ready) begin
                        acc         <= '0;
                        sad_valid_r <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sad_accumulator.sv
// tb_sad_accumulator
// Self-checking bench for sad_accumulator. A reference model tracks accepted
// pairs per block with plain arithmetic, predicts in_ready / sad_valid cycle
// by cycle and pushes each block's expected SAD into a queue; a separate
// monitor pops and compares whenever the engine completes a result handshake.
module tb_sad_accumulator;
    localparam int PIX_W   = 8;
    localparam int BLOCK_N = 16;
    localparam int SUM_W   = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;

    sad_accumulator_if #(.PIX_W(PIX_W), .SUM_W(SUM_W)) bus ();

    sad_accumulator #(.PIX_W(PIX_W), .BLOCK_N(BLOCK_N), .SUM_W(SUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned absdiff(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : b - a;
    endfunction

    // ---------------- reference model ----------------
    int unsigned cyc = 0;
    int unsigned exp_q[$];
    int unsigned run_sum = 0;
    int unsigned run_cnt = 0;
    int unsigned done_cyc = 0;
    bit          busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit exp_rdy;
        bit exp_vld;
        if (!rst_n) begin
            run_sum = 0;
            run_cnt = 0;
            busy    = 1'b0;
            exp_q.delete();
        end
        // Result appears in the second cycle after the cycle holding the last beat.
        exp_rdy = rst_n && !clear && !busy;
        exp_vld = busy && (cyc >= done_cyc + 2);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("sad_valid", 32'(bus.sad_valid), 32'(exp_vld));
        if (rst_n) begin
            if (clear) begin
                run_sum = 0;
                run_cnt = 0;
                busy    = 1'b0;
                exp_q.delete();
            end else begin
                if (exp_vld && bus.sad_ready) busy = 1'b0;
                if (bus.in_valid && exp_rdy) begin
                    run_sum += absdiff(32'(bus.pix_a), 32'(bus.pix_b));
                    run_cnt++;
                    if (run_cnt == BLOCK_N) begin
                        exp_q.push_back(run_sum);
                        busy     = 1'b1;
                        done_cyc = cyc;
                        run_sum  = 0;
                        run_cnt  = 0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          held = 1'b0;
    logic [SUM_W-1:0] held_sad = '0;

    always @(negedge clk) begin
        if (rst_n && !clear && bus.sad_valid) begin
            if (held) chk("sad_stable", 32'(bus.sad), 32'(held_sad));
            if (bus.sad_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sad_unexpected: got result %0d expected none (t=%0t)", bus.sad, $time);
                end else begin
                    chk("sad", 32'(bus.sad), exp_q.pop_front());
                end
                held = 1'b0;
            end else begin
                held     = 1'b1;
                held_sad = bus.sad;
            end
        end else begin
            held = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int unsigned n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        int unsigned n = 0;
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.pix_a    = a;
        bus.pix_b    = b;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no accept in %0d cycles expected accept", n);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic block(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < BLOCK_N; i++) beat(a, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.pix_a     = '0;
        bus.pix_b     = '0;
        bus.sad_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_sad_valid", 32'(bus.sad_valid), 0);
        chk("rst_sad", 32'(bus.sad), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Reset mid-block: state lost, no partial result, fresh block after.
        for (int i = 0; i < 5; i++) beat(8'(60 + i), 8'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        chk("midrst_sad_valid", 32'(bus.sad_valid), 0);
        chk("midrst_sad", 32'(bus.sad), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        block(8'd7, 8'd200);
        idle(4);

        // Positive, negative and maximum differences.
        block(8'd25, 8'd0);
        idle(4);
        block(8'd0, 8'd25);
        idle(4);
        block(8'd255, 8'd0);
        idle(4);

        // Backpressure in HOLD with beats offered meanwhile.
        bus.sad_ready = 1'b0;
        block(8'd9, 8'd4);
        bus.in_valid = 1'b1;
        bus.pix_a    = 8'd200;
        bus.pix_b    = 8'd0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.sad_ready = 1'b1;
        idle(3);
        block(8'd3, 8'd1);
        idle(4);

        // Bubbles between every beat.
        for (int i = 0; i < BLOCK_N; i++) begin
            beat(8'd10, 8'd4);
            idle(1);
        end
        idle(4);

        // Clear mid-block with a beat presented in the clear cycle.
        for (int i = 0; i < 7; i++) beat(8'd50, 8'd1);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.pix_a    = 8'd99;
        bus.pix_b    = 8'd0;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        block(8'd1, 8'd2);
        idle(4);

        // Clear while a result is pending in HOLD: the result is dropped.
        bus.sad_ready = 1'b0;
        block(8'd100, 8'd3);
        idle(3);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.sad_ready = 1'b1;
        idle(4);

        // Randomized traffic with bubbles, backpressure and occasional clear.
        repeat (600) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.pix_a     = 8'($urandom);
            bus.pix_b     = 8'($urandom);
            bus.sad_ready = ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        clear         = 1'b0;
        bus.sad_ready = 1'b1;
        idle(10);

        chk("results_outstanding", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
